// File: rtl/bus_hold_arbiter_if.sv
// Bus-hold arbiter port bundle: requester/CPU side (master) and arbiter side (slave).
// Latency: none, wires only.
// Backpressure: none here; req is a level held by each requester until it is done with the bus.
// Signals: req/grant per requester, preempt advisory, hold/holda CPU handshake,
//          busy, sticky hold_err, last_id of the most recent grantee.
interface bus_hold_arbiter_if #(
  parameter int N = 4
);
  logic [N-1:0] req;
  logic [N-1:0] grant;
  logic         preempt;
  logic         hold;
  logic         holda;
  logic         busy;
  logic         hold_err;
  logic [2:0]   last_id;

  modport master (
    output req, holda,
    input  grant, preempt, hold, busy, hold_err, last_id
  );

  modport slave (
    input  req, holda,
    output grant, preempt, hold, busy, hold_err, last_id
  );
endinterface

// File: rtl/bus_hold_arbiter.sv
// Bus-hold arbiter: raises CPU HOLD, waits for HOLDA, then grants the local bus round-robin to N masters.
// Latency: hold 1 clk after req; grant 1+SYNC_STAGES+1 clks after HOLDA rises; >=1 idle clk between grantees.
// Backpressure: grant is held while the owner keeps req; preempt only advises the owner to let go.
// Ports: clk, reset_n (async, active-low); bus (slave modport): req[N], holda in;
//        grant[N], preempt, hold, busy, hold_err (sticky), last_id[3] out.
module bus_hold_arbiter #(
  parameter int N           = 4,
  parameter int MAX_TENURE  = 64,
  parameter int HOLDA_TMO   = 255,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  bus_hold_arbiter_if.slave   bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HREQ  = 3'd1;
  localparam logic [2:0] S_ARB   = 3'd2;
  localparam logic [2:0] S_GNT   = 3'd3;
  localparam logic [2:0] S_HDROP = 3'd4;

  localparam int TW = $clog2(MAX_TENURE + 1);
  localparam int OW = $clog2(HOLDA_TMO + 1);

  logic [2:0]    state_q,    state_d;
  logic [TW-1:0] tenure_q,   tenure_d;
  logic [OW-1:0] tmo_q,      tmo_d;
  logic [N-1:0]  grant_q,    grant_d;
  logic          hold_q,     hold_d;
  logic          preempt_q,  preempt_d;
  logic          hold_err_q, hold_err_d;
  logic [2:0]    last_id_q,  last_id_d;
  logic [N-1:0]  own_mask_d;
  logic          holda_s;
  logic          pick_vld;
  logic [2:0]    pick_id;

  // HOLDA comes from the CPU pin; optionally pass it through a synchroniser chain.
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign holda_s = bus.holda;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q, sync_d;

      always_comb begin
        sync_d[0] = bus.holda;
        for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync_q <= '0;
        else          sync_q <= sync_d;
      end

      assign holda_s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // Round-robin pick: distance 0 is last_id+1, distance N-1 is last_id itself,
  // so a requester that just released is scanned last.
  always_comb begin
    int best_d;
    int d;
    best_d  = N;
    d       = 0;
    pick_id = last_id_q;
    for (int j = 0; j < N; j++) begin
      d = (j + N - 1 - int'(last_id_q)) % N;
      if (bus.req[j] && (d < best_d)) begin
        best_d  = d;
        pick_id = 3'(j);
      end
    end
    pick_vld = (best_d < N);
  end

  always_comb begin
    state_d    = state_q;
    tenure_d   = '0;
    tmo_d      = '0;
    hold_err_d = hold_err_q;
    last_id_d  = last_id_q;

    case (state_q)
      S_IDLE: begin
        if (|bus.req) state_d = S_HREQ;
      end
      // HOLD stays up until HOLDA even if req vanishes; ARB then sends us to HDROP.
      S_HREQ: begin
        tmo_d = tmo_q + 1'b1;
        if (holda_s) begin
          state_d = S_ARB;
        end else if (tmo_d == OW'(HOLDA_TMO)) begin
          hold_err_d = 1'b1;
          state_d    = S_HDROP;
        end
      end
      S_ARB: begin
        if (!holda_s) begin
          hold_err_d = 1'b1;
          state_d    = S_HDROP;
        end else if (!pick_vld) begin
          state_d = S_HDROP;
        end else begin
          last_id_d = pick_id;
          tenure_d  = TW'(1);
          state_d   = S_GNT;
        end
      end
      // grant_q is one-hot on last_id here, so req & grant_q is the owner's request.
      S_GNT: begin
        if (!holda_s) begin
          hold_err_d = 1'b1;
          state_d    = S_HDROP;
        end else if (!(|(bus.req & grant_q))) begin
          state_d = (|bus.req) ? S_ARB : S_HDROP;
        end else begin
          tenure_d = (tenure_q == TW'(MAX_TENURE)) ? tenure_q : tenure_q + 1'b1;
        end
      end
      S_HDROP: begin
        if (!holda_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they leave the flops with the state.
    own_mask_d = N'(1) << last_id_d;
    hold_d     = (state_d == S_HREQ) || (state_d == S_ARB) || (state_d == S_GNT);
    grant_d    = (state_d == S_GNT) ? own_mask_d : '0;
    preempt_d  = (state_d == S_GNT) && (tenure_d >= TW'(MAX_TENURE)) &&
                 (|(bus.req & ~own_mask_d));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      tenure_q   <= '0;
      tmo_q      <= '0;
      grant_q    <= '0;
      hold_q     <= 1'b0;
      preempt_q  <= 1'b0;
      hold_err_q <= 1'b0;
      last_id_q  <= 3'(N - 1);
    end else begin
      state_q    <= state_d;
      tenure_q   <= tenure_d;
      tmo_q      <= tmo_d;
      grant_q    <= grant_d;
      hold_q     <= hold_d;
      preempt_q  <= preempt_d;
      hold_err_q <= hold_err_d;
      last_id_q  <= last_id_d;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.hold     = hold_q;
  assign bus.preempt  = preempt_q;
  assign bus.hold_err = hold_err_q;
  assign bus.last_id  = last_id_q;
  assign bus.busy     = hold_q | (|grant_q);

endmodule

// File: tb/tb_bus_hold_arbiter.sv
module tb_bus_hold_arbiter;

  localparam int N    = 4;
  localparam int MAXT = 8;
  localparam int TMO  = 16;
  localparam int SYNC = 2;

  typedef struct packed {
    logic [N-1:0] grant;
    logic         hold;
    logic         preempt;
    logic         busy;
    logic         hold_err;
    logic [2:0]   last_id;
  } exp_t;

  typedef enum int {P_IDLE, P_HREQ, P_ARB, P_GNT, P_HDROP} ph_t;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  bus_hold_arbiter_if #(.N(N)) ifc ();

  bus_hold_arbiter #(
    .N(N), .MAX_TENURE(MAXT), .HOLDA_TMO(TMO), .SYNC_STAGES(SYNC)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifc)
  );

  exp_t  sb[$];
  string chk_name[$];
  int    chk_act[$];
  int    chk_exp[$];
  int    nvec = 0;
  int    nerr = 0;

  bit    cpu_force = 1'b0;
  logic  cpu_val   = 1'b0;
  int    cpu_dly   = 3;

  function automatic bit bit_of(input logic [N-1:0] v, input int i);
    return ((v >> i) & N'(1)) != '0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic post(input string nm, input int act, input int exp);
    chk_name.push_back(nm);
    chk_act.push_back(act);
    chk_exp.push_back(exp);
  endtask

  // CPU: HOLDA follows HOLD after cpu_dly clks unless forced.
  initial begin
    int cnt;
    cnt = 0;
    ifc.holda = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (!reset_n) begin
        ifc.holda = 1'b0;
        cnt = 0;
      end else if (cpu_force) begin
        ifc.holda = cpu_val;
      end else if (ifc.holda !== ifc.hold) begin
        if (cnt >= cpu_dly) begin
          ifc.holda = ifc.hold;
          cnt = 0;
        end else cnt++;
      end else cnt = 0;
    end
  end

  // Reference model: bus ownership phases, a HOLDA delay line and plain counters.
  initial begin
    ph_t          ph;
    int           owner, ten, waitc, c;
    bit           err, hs, found;
    bit           hq[$];
    logic [N-1:0] rq, own;
    exp_t         e;
    ph = P_IDLE; owner = N - 1; ten = 0; waitc = 0; err = 0;
    for (int i = 0; i < SYNC; i++) hq.push_back(1'b0);
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        ph = P_IDLE; owner = N - 1; ten = 0; waitc = 0; err = 0;
        hq.delete();
        for (int i = 0; i < SYNC; i++) hq.push_back(1'b0);
        if (clk) begin
          e = '0;
          e.last_id = 3'(N - 1);
          sb.push_back(e);
        end
      end else begin
        rq = ifc.req;
        if (SYNC == 0) hs = ifc.holda;
        else begin
          hs = hq.pop_front();
          hq.push_back(ifc.holda);
        end
        case (ph)
          P_IDLE:  if (rq != '0) begin ph = P_HREQ; waitc = 0; end
          P_HREQ: begin
            waitc++;
            if (hs) ph = P_ARB;
            else if (waitc == TMO) begin err = 1; ph = P_HDROP; end
          end
          P_ARB: begin
            if (!hs) begin err = 1; ph = P_HDROP; end
            else if (rq == '0) ph = P_HDROP;
            else begin
              found = 0;
              for (int k = 1; k <= N; k++) begin
                c = (owner + k) % N;
                if (!found && bit_of(rq, c)) begin owner = c; found = 1; end
              end
              ph = P_GNT; ten = 1;
            end
          end
          P_GNT: begin
            if (!hs) begin err = 1; ph = P_HDROP; end
            else if (!bit_of(rq, owner)) ph = (rq != '0) ? P_ARB : P_HDROP;
            else ten = (ten < MAXT) ? ten + 1 : MAXT;
          end
          P_HDROP: if (!hs) ph = P_IDLE;
          default: ph = P_IDLE;
        endcase
        own        = N'(1) << owner;
        e.hold     = (ph == P_HREQ) || (ph == P_ARB) || (ph == P_GNT);
        e.grant    = (ph == P_GNT) ? own : '0;
        e.preempt  = (ph == P_GNT) && (ten >= MAXT) && ((rq & ~own) != '0);
        e.busy     = e.hold || (e.grant != '0);
        e.hold_err = err;
        e.last_id  = 3'(owner);
        sb.push_back(e);
      end
    end
  end

  // Monitor: compares every cycle's outputs and drains posted directed checks.
  initial begin
    exp_t  e, a;
    string nm;
    int    ac, ex;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        a = {ifc.grant, ifc.hold, ifc.preempt, ifc.busy, ifc.hold_err, ifc.last_id};
        nvec++;
        if (a !== e) begin
          nerr++;
          $display("FAIL outputs @%0t: got grant=%b hold=%b preempt=%b busy=%b err=%b last=%0d, want grant=%b hold=%b preempt=%b busy=%b err=%b last=%0d",
                   $time, a.grant, a.hold, a.preempt, a.busy, a.hold_err, a.last_id,
                   e.grant, e.hold, e.preempt, e.busy, e.hold_err, e.last_id);
        end
      end
      while (chk_name.size() > 0) begin
        nm = chk_name.pop_front();
        ac = chk_act.pop_front();
        ex = chk_exp.pop_front();
        nvec++;
        if (ac != ex) begin
          nerr++;
          $display("FAIL %s: got %0d, want %0d", nm, ac, ex);
        end
      end
    end
  end

  task automatic rand_phase(input int cycles);
    int           held[$];
    int           dur[$];
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) begin held.push_back(0); dur.push_back(0); end
    for (int c = 0; c < cycles; c++) begin
      step();
      r = ifc.req;
      for (int i = 0; i < N; i++) begin
        if (bit_of(r, i)) begin
          if (bit_of(ifc.grant, i)) begin
            held[i]++;
            if (held[i] >= dur[i] || (ifc.preempt && held[i] >= MAXT + 2))
              r = r & ~(N'(1) << i);
          end
        end else if ($urandom_range(0, 7) == 0) begin
          r       = r | (N'(1) << i);
          held[i] = 0;
          dur[i]  = int'($urandom_range(1, 14));
        end
      end
      if ($urandom_range(0, 63) == 0) cpu_dly = int'($urandom_range(0, 4));
      ifc.req = r;
    end
  endtask

  initial begin
    logic [N-1:0] order[$];
    logic [N-1:0] exp_order[$];
    logic [N-1:0] prevg, r;
    int           gcnt, t0, t1;
    bit           seen, hold_lost;

    exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    ifc.req = '0;
    repeat (3) step();
    post("reset_last_id", int'(ifc.last_id), N - 1);
    @(negedge clk);
    #2 reset_n = 1'b1;

    // Round-robin with all four requesting, each releasing 5 clks into its tenure.
    step();
    ifc.req = 4'hF; prevg = '0; gcnt = 0; hold_lost = 0;
    for (int k = 0; k < 200 && order.size() < 5; k++) begin
      step();
      r = 4'hF;
      if (ifc.grant != '0) begin
        if (prevg == '0) begin order.push_back(ifc.grant); gcnt = 0; end
        gcnt++;
        if (gcnt == 5) r = 4'hF & ~ifc.grant;
      end else if (order.size() > 0 && !ifc.hold) hold_lost = 1;
      prevg   = ifc.grant;
      ifc.req = r;
    end
    for (int k = 0; k < 5; k++)
      post("rr_order", (k < order.size()) ? int'(order[k]) : -1, int'(exp_order[k]));
    post("rr_hold_kept", int'(hold_lost), 0);
    ifc.req = '0;
    repeat (15) step();

    // Single requester: full acquire/release cycle.
    ifc.req = 4'b0001; seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin step(); seen = (ifc.grant != '0); end
    post("single_grant", int'(ifc.grant), 1);
    repeat (3) step();
    ifc.req = '0;
    repeat (15) step();
    post("single_idle_busy", int'(ifc.busy), 0);
    post("single_idle_hold", int'(ifc.hold), 0);

    // Tenure limit: req[1] overstays while req[2] waits.
    ifc.req = 4'b0010; gcnt = 0; t0 = -1;
    for (int k = 0; k < 80 && t0 < 0; k++) begin
      step();
      if (ifc.grant[1]) begin
        gcnt++;
        if (gcnt == 2) ifc.req = ifc.req | 4'b0100;
        if (ifc.preempt) t0 = gcnt;
      end
    end
    post("preempt_tenure", t0, MAXT);
    ifc.req = 4'b0100; seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin step(); seen = (ifc.grant != '0); end
    post("after_preempt_grant", int'(ifc.grant), 4);
    post("after_preempt_clear", int'(ifc.preempt), 0);
    ifc.req = '0;
    repeat (15) step();

    // HOLDA never arrives.
    cpu_force = 1; cpu_val = 0;
    ifc.req = 4'b0001; t0 = -1; t1 = -1;
    for (int k = 0; k < 60 && t1 < 0; k++) begin
      step();
      if (t0 < 0 && ifc.hold) t0 = k;
      if (ifc.hold_err) t1 = k;
    end
    post("tmo_cycles", t1 - t0, TMO);
    post("tmo_hold_low", int'(ifc.hold), 0);
    ifc.req = '0; cpu_force = 0;
    repeat (4) step();
    post("tmo_err_sticky", int'(ifc.hold_err), 1);
    post("tmo_idle_busy", int'(ifc.busy), 0);

    // Asynchronous reset in the middle of a tenure.
    ifc.req = 4'b0100; seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin step(); seen = (ifc.grant != '0); end
    repeat (2) step();
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    post("async_grant", int'(ifc.grant), 0);
    post("async_hold", int'(ifc.hold), 0);
    post("async_busy", int'(ifc.busy), 0);
    post("async_err", int'(ifc.hold_err), 0);
    ifc.req = 4'hF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 reset_n = 1'b1;
    #1 post("post_reset_last_id", int'(ifc.last_id), N - 1);
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin step(); seen = (ifc.grant != '0); end
    post("post_reset_first", int'(ifc.grant), 1);
    ifc.req = '0;
    repeat (15) step();

    // HOLDA withdrawn while a master owns the bus.
    ifc.req = 4'b1000; seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin step(); seen = (ifc.grant != '0); end
    cpu_force = 1; cpu_val = 0; gcnt = 0;
    for (int k = 0; k < 10 && ifc.grant != '0; k++) begin step(); gcnt++; end
    post("viol_latency", gcnt, SYNC + 1);
    post("viol_err", int'(ifc.hold_err), 1);
    post("viol_hold", int'(ifc.hold), 0);
    ifc.req = '0; cpu_force = 0;
    repeat (8) step();

    // Random traffic; arbitration must continue despite the sticky error.
    rand_phase(2500);
    ifc.req = '0;
    repeat (20) step();
    post("rand_err_sticky", int'(ifc.hold_err), 1);
    post("rand_drain_busy", int'(ifc.busy), 0);

    @(negedge clk);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
